imem_load_controller: RTL and testbench

//   Owns the instruction memory write/read ports. In load mode it packs the debug-unit UART byte

---
 rtl/imem_load_controller.sv | 133 +++++++++++++
 tb/tb_imem_load_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_controller.sv
// Instruction-memory load controller: packs UART bytes into big-endian 32-bit words during load,
// then gates IF-stage reads once the program is in place. Optional inter-byte timeout: IMEM_LOAD_TIMEOUT_EN.
module imem_load_controller #(
  parameter int          MEMORY_WIDTH   = 32,
  parameter int          MEMORY_DEPTH   = 64,
  parameter int          NB_ADDR        = 6,
  parameter logic [31:0] HALT_WORD      = 32'hFFFF_FFFF,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_load_start,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  input  logic [NB_ADDR-1:0]   i_fetch_addr,
  input  logic                 i_fetch_en,
  output logic [NB_ADDR-1:0]   o_write_addr,
  output logic [31:0]          o_write_data,
  output logic                 o_write_enable,
  output logic [NB_ADDR-1:0]   o_read_addr,
  output logic                 o_read_enable,
  output logic                 o_busy,
  output logic                 o_load_done,
  output logic                 o_full,
`ifdef IMEM_LOAD_TIMEOUT_EN
  output logic                 o_timeout,
`endif
  output logic [NB_ADDR:0]     o_word_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WRITE, ST_DONE} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [1:0]          r_byte_cnt;
  logic [NB_ADDR:0]    r_word_count;
  logic                r_full;
  logic [23:0]         r_shift;
  logic [31:0]         r_word;
  logic                w_accept;
  logic                w_fourth;
  logic                w_halt;
  logic                w_last;

  // A byte arriving during WRITE starts the next word; r_word stays stable for the write itself.
  assign w_accept = i_rx_valid && !i_load_start && (r_state == ST_LOAD || r_state == ST_WRITE);
  assign w_fourth = w_accept && (r_byte_cnt == 2'd3);
  assign w_halt   = (r_word == HALT_WORD);
  assign w_last   = ((r_word_count + 1'b1) == (NB_ADDR+1)'(MEMORY_DEPTH));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  w_next_state = ST_IDLE;
      ST_LOAD:  if (w_fourth) w_next_state = ST_WRITE;
      ST_WRITE: w_next_state = (w_halt || w_last) ? ST_DONE : ST_LOAD;
      ST_DONE:  w_next_state = ST_DONE;
      default:  w_next_state = ST_IDLE;
    endcase
    if (i_load_start) w_next_state = ST_LOAD;
  end

`ifdef IMEM_LOAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_idle_cnt;
  logic          r_timeout;
  logic          w_tmo_fire;

  assign w_tmo_fire = (r_state == ST_LOAD) && (r_byte_cnt != 2'd0) && !i_rx_valid && !i_load_start &&
                      (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign o_timeout  = r_timeout;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (i_load_start || i_rx_valid || r_state != ST_LOAD || r_byte_cnt == 2'd0) begin
      r_idle_cnt <= '0;
      if (i_load_start) r_timeout <= 1'b0;
    end else if (w_tmo_fire) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b1;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  logic w_tmo_fire;
  assign w_tmo_fire = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_byte_cnt   <= 2'd0;
      r_word_count <= '0;
      r_full       <= 1'b0;
    end else if (i_load_start) begin
      r_byte_cnt   <= 2'd0;
      r_word_count <= '0;
      r_full       <= 1'b0;
    end else begin
      if (w_accept)        r_byte_cnt <= r_byte_cnt + 1'b1;
      else if (w_tmo_fire) r_byte_cnt <= 2'd0;
      if (r_state == ST_WRITE) begin
        r_word_count <= r_word_count + 1'b1;
        if (w_last && !w_halt) r_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_accept) r_shift <= {r_shift[15:0], i_rx_data};
    if (w_fourth) r_word  <= {r_shift, i_rx_data};
  end

  always_comb begin
    o_write_enable = (r_state == ST_WRITE);
    o_write_addr   = o_write_enable ? r_word_count[NB_ADDR-1:0] : '0;
    o_write_data   = o_write_enable ? r_word : '0;
    o_read_addr    = i_fetch_addr;
    o_read_enable  = (r_state == ST_DONE) && i_fetch_en;
    o_busy         = (r_state == ST_LOAD) || (r_state == ST_WRITE);
    o_load_done    = (r_state == ST_DONE);
    o_full         = r_full;
    o_word_count   = r_word_count;
  end

endmodule

// File: tb/tb_imem_load_controller.sv
// Directed bench for imem_load_controller; memory writes are logged and compared to hand-computed words.
module tb_imem_load_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [5:0]  fetch_addr = 6'd0;
  logic        fetch_en = 1'b0;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [5:0]  rd_addr;
  logic        rd_en;
  logic        busy;
  logic        done;
  logic        full;
  logic [6:0]  wcnt;
`ifdef IMEM_LOAD_TIMEOUT_EN
  logic        tmo;
`endif

  int total = 0;
  int bad   = 0;
  logic [5:0]  log_addr[$];
  logic [31:0] log_data[$];

  imem_load_controller dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_load_start(load_start),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_fetch_addr(fetch_addr), .i_fetch_en(fetch_en),
    .o_write_addr(wr_addr), .o_write_data(wr_data), .o_write_enable(wr_en),
    .o_read_addr(rd_addr), .o_read_enable(rd_en),
    .o_busy(busy), .o_load_done(done), .o_full(full),
`ifdef IMEM_LOAD_TIMEOUT_EN
    .o_timeout(tmo),
`endif
    .o_word_count(wcnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wen", wr_en, 0);
    chk("rst_cnt", wcnt, 0);
    chk("rst_full", full, 0);
    rst_n = 1'b1;
    idle(2);
    chk("idle_busy", busy, 0);

    // 1: three words ending with HALT
    pulse_start();
    chk("t1_busy", busy, 1);
    send_word(32'h0000_000A);
    chk("t1_latency_wen", wr_en, 1);
    send_word(32'h0000_0014);
    send_word(32'hFFFF_FFFF);
    idle(3);
    chk("t1_nwr", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      chk("t1_a0", log_addr[0], 0); chk("t1_d0", log_data[0], 32'd10);
      chk("t1_a1", log_addr[1], 1); chk("t1_d1", log_data[1], 32'd20);
      chk("t1_a2", log_addr[2], 2); chk("t1_d2", log_data[2], 32'hFFFF_FFFF);
    end
    chk("t1_done", done, 1);
    chk("t1_cnt", wcnt, 3);
    chk("t1_full", full, 0);
    chk("t1_busy_end", busy, 0);

    // 2: fetch pass-through in DONE; bytes ignored
    fetch_en = 1'b1; fetch_addr = 6'd1;
    #1;
    chk("t2_ren", rd_en, 1);
    chk("t2_raddr", rd_addr, 1);
    send_word(32'h1234_5678);
    idle(3);
    chk("t2_nwr", log_addr.size(), 3);
    chk("t2_cnt", wcnt, 3);

    // 3: fill all 64 words without HALT
    clear_log();
    pulse_start();
    chk("t3_done_cleared", done, 0);
    chk("t3_ren_blocked", rd_en, 0);
    for (int i = 0; i < 64; i++) send_word(32'(i + 1));
    idle(3);
    chk("t3_nwr", log_addr.size(), 64);
    if (log_addr.size() == 64)
      for (int i = 0; i < 64; i++) begin
        chk($sformatf("t3_a%0d", i), log_addr[i], i);
        chk($sformatf("t3_d%0d", i), log_data[i], i + 1);
      end
    chk("t3_done", done, 1);
    chk("t3_full", full, 1);
    chk("t3_cnt", wcnt, 64);

    // 4: partial word discarded on restart; byte coinciding with load_start dropped
    clear_log();
    pulse_start();
    chk("t4_full_cleared", full, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    chk("t4_ren_blocked", rd_en, 0);
    rx_data = 8'hAA; rx_valid = 1'b1;
    pulse_start();
    rx_valid = 1'b0;
    send_word(32'h0000_0028);
    idle(3);
    chk("t4_nwr", log_addr.size(), 1);
    if (log_addr.size() == 1) begin
      chk("t4_a0", log_addr[0], 0);
      chk("t4_d0", log_data[0], 32'd40);
    end
    chk("t4_cnt", wcnt, 1);
    chk("t4_busy", busy, 1);
    chk("t4_done", done, 0);

    // 5: async reset mid-word
    clear_log();
    fetch_en = 1'b0; fetch_addr = 6'd0;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_cnt", wcnt, 0);
    chk("t5_wen", wr_en, 0);
    chk("t5_waddr", wr_addr, 0);
    chk("t5_wdata", wr_data, 0);
    chk("t5_ren", rd_en, 0);
    chk("t5_full", full, 0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    send_byte(8'h03);
    send_byte(8'h04);
    send_word(32'h0000_0055);
    idle(3);
    chk("t5_nwr", log_addr.size(), 0);
    chk("t5_busy_after", busy, 0);

`ifdef IMEM_LOAD_TIMEOUT_EN
    // 6: inter-byte timeout drops the partial word
    clear_log();
    pulse_start();
    chk("t6_tmo_clear", tmo, 0);
    send_byte(8'h99);
    idle(1005);
    chk("t6_tmo", tmo, 1);
    send_word(32'h1122_3344);
    idle(3);
    chk("t6_nwr", log_addr.size(), 1);
    if (log_addr.size() == 1) begin
      chk("t6_a0", log_addr[0], 0);
      chk("t6_d0", log_data[0], 32'h1122_3344);
    end
    pulse_start();
    chk("t6_tmo_cleared", tmo, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
